// File: rtl/softmax_frame_sequencer.sv
// Buffers one frame of single-precision words and issues them to the softmax core
// as spaced strobes. Optional WAIT watchdog + core recovery: SOFTMAX_SEQ_TIMEOUT_EN.
module softmax_frame_sequencer #(
  parameter int data_width     = 32,
  parameter int number_of_data = 10,
  parameter int gap_cycles     = 1
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
  , parameter int timeout_cycles = 1024
`endif
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  s_valid_i,
  input  logic [data_width-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  core_data_valid_o,
  output logic [data_width-1:0] core_data_o,
  input  logic                  core_done_i,
  output logic                  core_reset_n_o,
  output logic                  busy_o,
  output logic [15:0]           frame_count_o,
  output logic                  error_o
);
  localparam int IW = (number_of_data > 1) ? $clog2(number_of_data) : 1;
  localparam int GW = (gap_cycles > 0) ? $clog2(gap_cycles + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(number_of_data - 1);
  localparam logic [GW-1:0] GAP  = GW'(gap_cycles);

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  localparam logic [TW-1:0] TMAX = TW'(timeout_cycles - 1);
  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, RECOVER} state_e;
  logic [TW-1:0] wait_q;
  logic          rec_q, err_q;
`else
  typedef enum logic [1:0] {LOAD, ISSUE, WAIT} state_e;
`endif

  state_e                state_q, state_d;
  logic [data_width-1:0] fbuf_q [number_of_data];
  logic [IW-1:0]         wr_idx_q, rd_idx_q, rd_nxt;
  logic [GW-1:0]         gap_q;
  logic                  ready_q, valid_q, rstn_q, busy_q, accept;
  logic [data_width-1:0] data_q;
  logic [15:0]           fc_q;

  assign rd_nxt = rd_idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    accept  = (state_q == LOAD) && s_valid_i && ready_q;
    case (state_q)
      LOAD:  if (accept && wr_idx_q == LAST) state_d = ISSUE;
      // rd_idx_q names the word on the output; leave once the last one has strobed
      ISSUE: if (valid_q && rd_idx_q == LAST) state_d = WAIT;
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
      WAIT: begin
        if (core_done_i)         state_d = LOAD;
        else if (wait_q == TMAX) state_d = RECOVER;
      end
      RECOVER: if (rec_q) state_d = LOAD;
`else
      WAIT:  if (core_done_i) state_d = LOAD;
`endif
      default: state_d = LOAD;
    endcase
  end

  // Frame storage is deliberately left out of reset.
  always_ff @(posedge clock_i) begin
    if (accept) fbuf_q[wr_idx_q] <= s_data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      gap_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      rstn_q   <= 1'b0;
      busy_q   <= 1'b0;
      fc_q     <= '0;
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
      wait_q   <= '0;
      rec_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == LOAD);
      busy_q  <= (state_d != LOAD);
      valid_q <= 1'b0;
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
      rstn_q  <= (state_d != RECOVER);
`else
      rstn_q  <= 1'b1;
`endif
      case (state_q)
        LOAD: if (accept) begin
          if (wr_idx_q == LAST) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            gap_q    <= GAP;
            valid_q  <= 1'b1;
            data_q   <= fbuf_q[0];
          end else begin
            wr_idx_q <= wr_idx_q + IW'(1);
          end
        end
        ISSUE: begin
          if (state_d == ISSUE) begin
            if (gap_q == '0) begin
              valid_q  <= 1'b1;
              data_q   <= fbuf_q[rd_nxt];
              rd_idx_q <= rd_nxt;
              gap_q    <= GAP;
            end else begin
              gap_q <= gap_q - GW'(1);
            end
          end
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
          else wait_q <= '0;
`endif
        end
        WAIT: begin
          if (state_d == LOAD) fc_q <= fc_q + 16'd1;
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
          else if (state_d == RECOVER) begin
            err_q <= 1'b1;
            rec_q <= 1'b0;
          end else wait_q <= wait_q + TW'(1);
`endif
        end
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
        RECOVER: rec_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign s_ready_o         = ready_q;
  assign core_data_valid_o = valid_q;
  assign core_data_o       = data_q;
  assign core_reset_n_o    = rstn_q;
  assign busy_o            = busy_q;
  assign frame_count_o     = fc_q;
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_softmax_frame_sequencer.sv
// Bench for softmax_frame_sequencer: two instances (gap 1 and gap 0) driven with
// random frames and checked against expected strobe timing derived from frame rules.
module tb_softmax_frame_sequencer;
  localparam int N  = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic          s_valid [2];
  logic [DW-1:0] s_data  [2];
  logic          done    [2];
  logic          rdy [2], cvld [2], crstn [2], busy [2], err [2];
  logic [DW-1:0] cdata [2];
  logic [15:0]   fc [2];

  int n_chk  = 0;
  int n_fail = 0;
  int exp_fc [2];
  logic [DW-1:0] last_data [2];
  logic [DW-1:0] words [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    softmax_frame_sequencer #(
      .data_width(DW), .number_of_data(N), .gap_cycles(g == 0 ? 1 : 0)
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
      , .timeout_cycles(16)
`endif
    ) u_dut (
      .clock_i(clk), .reset_i(rst),
      .s_valid_i(s_valid[g]), .s_data_i(s_data[g]), .s_ready_o(rdy[g]),
      .core_data_valid_o(cvld[g]), .core_data_o(cdata[g]), .core_done_i(done[g]),
      .core_reset_n_o(crstn[g]), .busy_o(busy[g]), .frame_count_o(fc[g]), .error_o(err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic gen_words(input bit fixed);
    for (int i = 0; i < N; i++) words[i] = $urandom;
    if (fixed) begin
      words[0] = 32'h3F000000; words[1] = 32'h3F000000;
      words[2] = 32'h3E9EB851; words[N-1] = 32'h3F7851EB;
    end
  endtask

  // Ready is expected high throughout LOAD, so every valid cycle is an accept.
  task automatic load_frame(input int d, input bit bub, output int ncyc);
    int idx;
    bit v;
    idx = 0; ncyc = 0;
    while (idx < N && ncyc < 4*N) begin
      v = bub ? (ncyc % 2 == 0) : 1'b1;
      check($sformatf("ready_load%0d", d), 32'(rdy[d]), 1);
      check($sformatf("no_strobe_load%0d", d), 32'(cvld[d]), 0);
      s_valid[d] = v;
      s_data[d]  = v ? words[idx] : $urandom;
      tick();
      if (v) idx++;
      ncyc++;
    end
    s_valid[d] = 1'b0;
    check($sformatf("load_complete%0d", d), idx, N);
  endtask

  // Cycle t after the last accept: strobe when t is a multiple of (gap+1).
  task automatic issue_phase(input int d, input int done_t, input int ncyc_max);
    int g, len;
    bit stb;
    g = gap_of(d);
    len = (N-1)*(g+1) + 1;
    for (int t = 0; t < len && t < ncyc_max; t++) begin
      s_valid[d] = 1'b1;
      s_data[d]  = $urandom;
      done[d]    = (t == done_t);
      stb = (t % (g+1) == 0);
      if (stb) last_data[d] = words[t/(g+1)];
      check($sformatf("strobe%0d_t%0d", d, t), 32'(cvld[d]), 32'(stb));
      check($sformatf("data%0d_t%0d", d, t), cdata[d], last_data[d]);
      check($sformatf("ready_issue%0d", d), 32'(rdy[d]), 0);
      check($sformatf("busy_issue%0d", d), 32'(busy[d]), 1);
      check($sformatf("fc_issue%0d", d), 32'(fc[d]), exp_fc[d]);
      tick();
    end
    done[d] = 1'b0;
    s_valid[d] = 1'b0;
  endtask

  task automatic wait_phase(input int d, input int extra);
    for (int i = 0; i <= extra; i++) begin
      check($sformatf("wait_nostrobe%0d", d), 32'(cvld[d]), 0);
      check($sformatf("wait_busy%0d", d), 32'(busy[d]), 1);
      check($sformatf("wait_ready%0d", d), 32'(rdy[d]), 0);
      check($sformatf("wait_hold%0d", d), cdata[d], last_data[d]);
      tick();
    end
    done[d] = 1'b1;
    tick();
    done[d] = 1'b0;
    exp_fc[d] = (exp_fc[d] + 1) % 65536;
    check($sformatf("done_ready%0d", d), 32'(rdy[d]), 1);
    check($sformatf("done_busy%0d", d), 32'(busy[d]), 0);
    check($sformatf("done_fc%0d", d), 32'(fc[d]), exp_fc[d]);
    check($sformatf("done_nostrobe%0d", d), 32'(cvld[d]), 0);
  endtask

  task automatic run_frame(input int d, input bit bub, input bit fixed, input int done_t);
    int nc;
    gen_words(fixed);
    load_frame(d, bub, nc);
    check($sformatf("load_cycles%0d", d), nc, bub ? 2*N-1 : N);
    issue_phase(d, done_t, 1000);
    wait_phase(d, $urandom_range(0, 5));
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(rdy[d]), 0);
      check($sformatf("rst_valid%0d", d), 32'(cvld[d]), 0);
      check($sformatf("rst_data%0d", d), cdata[d], 0);
      check($sformatf("rst_crstn%0d", d), 32'(crstn[d]), 0);
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 0);
      check($sformatf("rst_fc%0d", d), 32'(fc[d]), 0);
      check($sformatf("rst_err%0d", d), 32'(err[d]), 0);
      exp_fc[d] = 0;
      last_data[d] = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0; s_data[d] = '0; done[d] = 1'b0;
    end
    tick(); tick(); tick();
    check_reset_state();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rel_crstn%0d", d), 32'(crstn[d]), 1);
      check($sformatf("rel_ready%0d", d), 32'(rdy[d]), 1);
    end

    run_frame(0, 1'b0, 1'b1, -1);   // basic frame, fixed words
    run_frame(0, 1'b1, 1'b0, -1);   // upstream bubbles
    run_frame(1, 1'b0, 1'b0, -1);   // zero gap
    run_frame(0, 1'b0, 1'b0, 5);    // done during ISSUE ignored
    run_frame(1, 1'b0, 1'b0, 3);
    for (int i = 0; i < 4; i++)
      run_frame(int'($urandom_range(0, 1)), 1'(($urandom_range(0, 1))), 1'b0, -1);

    // Reset right after the 4th strobe of a gap-1 frame.
    gen_words(1'b0);
    begin
      int nc;
      load_frame(0, 1'b0, nc);
    end
    issue_phase(0, -1, 3*2 + 1);
    rst = 1'b1;
    tick();
    check_reset_state();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("post_rst_crstn", 32'(crstn[0]), 1);
      check("post_rst_ready", 32'(rdy[0]), 1);
      check("post_rst_nostrobe", 32'(cvld[0]), 0);
      check("post_rst_fc", 32'(fc[0]), 0);
      tick();
    end
    run_frame(0, 1'b0, 1'b0, -1);

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
    gen_words(1'b0);
    begin
      int nc;
      load_frame(0, 1'b0, nc);
    end
    issue_phase(0, -1, 1000);
    for (int i = 0; i < 16; i++) begin
      check("to_wait_err", 32'(err[0]), 0);
      check("to_wait_crstn", 32'(crstn[0]), 1);
      check("to_wait_busy", 32'(busy[0]), 1);
      tick();
    end
    check("to_rec1_err", 32'(err[0]), 1);
    check("to_rec1_crstn", 32'(crstn[0]), 0);
    tick();
    check("to_rec2_crstn", 32'(crstn[0]), 0);
    tick();
    check("to_load_crstn", 32'(crstn[0]), 1);
    check("to_load_ready", 32'(rdy[0]), 1);
    check("to_load_busy", 32'(busy[0]), 0);
    check("to_load_fc", 32'(fc[0]), exp_fc[0]);
    run_frame(0, 1'b0, 1'b0, -1);
    check("to_err_sticky", 32'(err[0]), 1);
`else
    check("err_tied0", 32'(err[0]), 0);
    check("err_tied1", 32'(err[1]), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
